// File: rtl/hsst_link_rst_supervisor.sv
// ---------------------------------------------------------------------------
// hsst_link_rst_supervisor
//
// Sequences the HSST TX/RX soft-reset inputs of the PIPE reset controller.
// A stalled TX PLL bring-up is timed out and answered with a TX PLL soft
// reset pulse. Enabled lanes that fail to reach channel-ready are kicked
// with per-lane RX soft reset pulses, chosen round-robin. Once a phase has
// used up its retries, the supervisor parks in FAIL until en drops.
//
// Handshake semantics: none of the ports are valid/ready handshakes. All
// inputs are level-sampled on every rising clk edge and all outputs are
// registered levels, except wtchdg_clr, which is a one-cycle pulse.
//
// Ports
//   clk               in   free-running reset-controller clock
//   rst               in   synchronous active-high reset
//   en                in   supervisor enable; low forces IDLE next cycle
//   lane_mask[3:0]    in   lanes in use; latched on IDLE->WAIT_TX only
//   tx_rst_done       in   TX reset sequence complete
//   hsst_ch_ready[3:0]in   per-lane channel ready
//   txpll_soft_rst_n  out  TX PLL soft reset, active low
//   rxlane_soft_rst_n out  per-lane RX soft reset, active low
//   wtchdg_clr        out  one-cycle pulse on every entry to MONITOR
//   link_ok           out  high while in MONITOR
//   fail              out  high while in FAIL
//   sup_state[2:0]    out  current FSM state (debug)
// ---------------------------------------------------------------------------
module hsst_link_rst_supervisor #(
  parameter int                CNT_W     = 20,
  parameter logic [CNT_W-1:0]  TX_TMO    = 20'hF0000,
  parameter logic [CNT_W-1:0]  RX_TMO    = 20'hF0000,
  parameter int                RST_PULSE = 16,
  parameter int                MAX_RETRY = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] lane_mask,
  input  logic       tx_rst_done,
  input  logic [3:0] hsst_ch_ready,
  output logic       txpll_soft_rst_n,
  output logic [3:0] rxlane_soft_rst_n,
  output logic       wtchdg_clr,
  output logic       link_ok,
  output logic       fail,
  output logic [2:0] sup_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_TX = 3'd1,
    TX_RST  = 3'd2,
    WAIT_RX = 3'd3,
    SCAN    = 3'd4,
    RX_RST  = 3'd5,
    MONITOR = 3'd6,
    FAILED  = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] TX_LAST    = TX_TMO - CNT_W'(1);
  localparam logic [CNT_W-1:0] RX_LAST    = RX_TMO - CNT_W'(1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(RST_PULSE - 1);
  localparam logic [3:0]       RETRY_MAX  = 4'(MAX_RETRY);

  state_t           state;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] timer_inc;
  logic [3:0]       mask_q;
  logic [3:0]       tx_retry;
  logic [3:0]       rx_retry [4];
  logic [1:0]       rr_ptr;

  logic             ready_all;
  logic             scan_hit;
  logic [1:0]       scan_lane;
  logic [1:0]       scan_idx;

  assign sup_state = state;
  assign ready_all = ((hsst_ch_ready & mask_q) == mask_q);
  // Timer saturates at all-ones; it is cleared on every state entry so the
  // equality compares never see a wrapped value.
  assign timer_inc = (timer == '1) ? timer : timer + CNT_W'(1);

  // Round-robin search: first masked, not-ready lane starting one past the
  // lane serviced last. rr_ptr itself is visited last (offset 4 wraps to 0).
  always_comb begin
    scan_hit  = 1'b0;
    scan_lane = rr_ptr;
    scan_idx  = rr_ptr;
    for (int i = 1; i <= 4; i++) begin
      scan_idx = rr_ptr + 2'(i);
      if (!scan_hit && mask_q[scan_idx] && !hsst_ch_ready[scan_idx]) begin
        scan_hit  = 1'b1;
        scan_lane = scan_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      timer             <= '0;
      mask_q            <= '0;
      tx_retry          <= '0;
      for (int i = 0; i < 4; i++) rx_retry[i] <= '0;
      rr_ptr            <= '0;
      txpll_soft_rst_n  <= 1'b1;
      rxlane_soft_rst_n <= 4'hF;
      wtchdg_clr        <= 1'b0;
      link_ok           <= 1'b0;
      fail              <= 1'b0;
    end else if (!en) begin
      // Abort anything in progress; soft resets release in the same cycle.
      state             <= IDLE;
      timer             <= '0;
      txpll_soft_rst_n  <= 1'b1;
      rxlane_soft_rst_n <= 4'hF;
      wtchdg_clr        <= 1'b0;
      link_ok           <= 1'b0;
      fail              <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mask_q   <= lane_mask;
          timer    <= '0;
          tx_retry <= '0;
          for (int i = 0; i < 4; i++) rx_retry[i] <= '0;
          // Park the pointer on lane 3 so the first search begins at lane 0.
          rr_ptr   <= 2'd3;
          state    <= WAIT_TX;
        end

        WAIT_TX: begin
          if (tx_rst_done) begin
            state <= WAIT_RX;
            timer <= '0;
          end else if (timer == TX_LAST) begin
            timer <= '0;
            if (tx_retry < RETRY_MAX) begin
              state            <= TX_RST;
              txpll_soft_rst_n <= 1'b0;
              tx_retry         <= (tx_retry == 4'hF) ? tx_retry : tx_retry + 4'd1;
            end else begin
              state <= FAILED;
              fail  <= 1'b1;
            end
          end else begin
            timer <= timer_inc;
          end
        end

        TX_RST: begin
          if (timer == PULSE_LAST) begin
            txpll_soft_rst_n <= 1'b1;
            state            <= WAIT_TX;
            timer            <= '0;
          end else begin
            timer <= timer_inc;
          end
        end

        WAIT_RX: begin
          if (!tx_rst_done) begin
            state <= WAIT_TX;
            timer <= '0;
          end else if (ready_all) begin
            state      <= MONITOR;
            link_ok    <= 1'b1;
            wtchdg_clr <= 1'b1;
            tx_retry   <= '0;
            for (int i = 0; i < 4; i++) rx_retry[i] <= '0;
            timer      <= '0;
          end else if (timer == RX_LAST) begin
            state <= SCAN;
            timer <= '0;
          end else begin
            timer <= timer_inc;
          end
        end

        SCAN: begin
          timer <= '0;
          if (scan_hit) begin
            rr_ptr <= scan_lane;
            if (rx_retry[scan_lane] >= RETRY_MAX) begin
              state <= FAILED;
              fail  <= 1'b1;
            end else begin
              state                <= RX_RST;
              rxlane_soft_rst_n    <= ~(4'b0001 << scan_lane);
              rx_retry[scan_lane]  <= (rx_retry[scan_lane] == 4'hF) ?
                                      rx_retry[scan_lane] : rx_retry[scan_lane] + 4'd1;
            end
          end else begin
            state <= WAIT_RX;
          end
        end

        RX_RST: begin
          if (timer == PULSE_LAST) begin
            rxlane_soft_rst_n <= 4'hF;
            state             <= WAIT_RX;
            timer             <= '0;
          end else begin
            timer <= timer_inc;
          end
        end

        MONITOR: begin
          wtchdg_clr <= 1'b0;
          if (!tx_rst_done) begin
            state   <= WAIT_TX;
            link_ok <= 1'b0;
            timer   <= '0;
          end else if (!ready_all) begin
            state   <= WAIT_RX;
            link_ok <= 1'b0;
            timer   <= '0;
          end
        end

        FAILED: begin
          fail              <= 1'b1;
          txpll_soft_rst_n  <= 1'b1;
          rxlane_soft_rst_n <= 4'hF;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hsst_link_rst_supervisor.sv
// ---------------------------------------------------------------------------
// tb_hsst_link_rst_supervisor
//
// Directed bench for hsst_link_rst_supervisor with TX_TMO=16, RX_TMO=32,
// RST_PULSE=4, MAX_RETRY=2. A table of per-cycle vectors covers reset,
// bring-up to MONITOR, lane drop, the tx-drop priority, en abort and the
// empty-mask case; hand-written loops cover the TX retry/FAIL path, the
// round-robin RX retry path and an en abort mid RX pulse.
// Inputs are driven 1ns after the rising edge; outputs are checked at the
// same point, so every expected value describes the state after that edge.
// ---------------------------------------------------------------------------
module tb_hsst_link_rst_supervisor;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [3:0] lane_mask = 4'h0;
  logic       tx_rst_done = 1'b0;
  logic [3:0] hsst_ch_ready = 4'h0;
  logic       txpll_soft_rst_n;
  logic [3:0] rxlane_soft_rst_n;
  logic       wtchdg_clr;
  logic       link_ok;
  logic       fail;
  logic [2:0] sup_state;

  always #5 clk = ~clk;

  hsst_link_rst_supervisor #(
    .CNT_W    (20),
    .TX_TMO   (20'd16),
    .RX_TMO   (20'd32),
    .RST_PULSE(4),
    .MAX_RETRY(2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .en               (en),
    .lane_mask        (lane_mask),
    .tx_rst_done      (tx_rst_done),
    .hsst_ch_ready    (hsst_ch_ready),
    .txpll_soft_rst_n (txpll_soft_rst_n),
    .rxlane_soft_rst_n(rxlane_soft_rst_n),
    .wtchdg_clr       (wtchdg_clr),
    .link_ok          (link_ok),
    .fail             (fail),
    .sup_state        (sup_state)
  );

  localparam logic [2:0] S_IDLE = 3'd0, S_WTX = 3'd1, S_TXR = 3'd2, S_WRX = 3'd3,
                         S_SCAN = 3'd4, S_RXR = 3'd5, S_MON = 3'd6, S_FAIL = 3'd7;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act);
    logic [31:0] exp;
    exp = exp_q.pop_front();
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; lane_mask = 4'h0; tx_rst_done = 1'b0; hsst_ch_ready = 4'h0;
    tick();
    rst = 1'b0;
  endtask

  task automatic check_one_hot_reset();
    expect_val(32'd0);
    check("two_soft_resets", 32'(!txpll_soft_rst_n && (rxlane_soft_rst_n != 4'hF)) |
                             32'($countones(~rxlane_soft_rst_n) > 1));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] mask;
    logic       tx;
    logic [3:0] rdy;
    logic [2:0] st;
    logic       txn;
    logic [3:0] rxn;
    logic       wd;
    logic       ok;
    logic       fl;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic r, input logic e, input logic [3:0] m, input logic t,
                     input logic [3:0] rd, input logic [2:0] st, input logic txn,
                     input logic [3:0] rxn, input logic wd, input logic ok, input logic fl);
    vec_t v;
    v.rst = r; v.en = e; v.mask = m; v.tx = t; v.rdy = rd;
    v.st = st; v.txn = txn; v.rxn = rxn; v.wd = wd; v.ok = ok; v.fl = fl;
    tv.push_back(v);
  endtask

  initial begin
    // rst en mask tx rdy | state txn rxn wd ok fail
    add(1, 0, 4'h0, 0, 4'h0, S_IDLE, 1, 4'hF, 0, 0, 0); // reset values
    add(0, 1, 4'hF, 0, 4'h0, S_WTX,  1, 4'hF, 0, 0, 0); // IDLE -> WAIT_TX
    add(0, 1, 4'h0, 1, 4'h0, S_WRX,  1, 4'hF, 0, 0, 0); // tx done
    add(0, 1, 4'h0, 1, 4'hF, S_MON,  1, 4'hF, 1, 1, 0); // all ready, wd pulse
    add(0, 1, 4'h0, 1, 4'hF, S_MON,  1, 4'hF, 0, 1, 0); // wd only one cycle
    add(0, 1, 4'h0, 1, 4'hD, S_WRX,  1, 4'hF, 0, 0, 0); // lane1 drop
    add(0, 1, 4'h0, 1, 4'hF, S_MON,  1, 4'hF, 1, 1, 0); // re-entry pulses again
    add(0, 1, 4'h0, 0, 4'hD, S_WTX,  1, 4'hF, 0, 0, 0); // tx drop beats lane drop
    add(0, 1, 4'h0, 1, 4'hF, S_WRX,  1, 4'hF, 0, 0, 0);
    add(0, 1, 4'h0, 1, 4'hF, S_MON,  1, 4'hF, 1, 1, 0);
    add(0, 0, 4'h0, 1, 4'hF, S_IDLE, 1, 4'hF, 0, 0, 0); // en low -> IDLE
    add(0, 1, 4'h0, 0, 4'h0, S_WTX,  1, 4'hF, 0, 0, 0); // mask=0 latched
    add(0, 1, 4'hF, 1, 4'h0, S_WRX,  1, 4'hF, 0, 0, 0);
    add(0, 1, 4'hF, 1, 4'h0, S_MON,  1, 4'hF, 1, 1, 0); // empty mask -> MONITOR
    add(0, 1, 4'hF, 1, 4'h0, S_MON,  1, 4'hF, 0, 1, 0); // mask change ignored
    add(0, 1, 4'h3, 1, 4'h0, S_MON,  1, 4'hF, 0, 1, 0);
    add(1, 1, 4'hF, 1, 4'hF, S_IDLE, 1, 4'hF, 0, 0, 0); // rst mid-operation
    add(0, 0, 4'hF, 1, 4'hF, S_IDLE, 1, 4'hF, 0, 0, 0);
  end

  // ---------------- stimulus ----------------
  initial begin
    logic       exp_low;
    logic [3:0] exp_rxn;
    int         p;

    #2;
    // Table-driven section.
    for (int i = 0; i < tv.size(); i++) begin
      rst = tv[i].rst; en = tv[i].en; lane_mask = tv[i].mask;
      tx_rst_done = tv[i].tx; hsst_ch_ready = tv[i].rdy;
      tick();
      expect_val(32'(tv[i].st));  check($sformatf("v%0d_state", i), 32'(sup_state));
      expect_val(32'(tv[i].txn)); check($sformatf("v%0d_txpll_n", i), 32'(txpll_soft_rst_n));
      expect_val(32'(tv[i].rxn)); check($sformatf("v%0d_rxlane_n", i), 32'(rxlane_soft_rst_n));
      expect_val(32'(tv[i].wd));  check($sformatf("v%0d_wtchdg_clr", i), 32'(wtchdg_clr));
      expect_val(32'(tv[i].ok));  check($sformatf("v%0d_link_ok", i), 32'(link_ok));
      expect_val(32'(tv[i].fl));  check($sformatf("v%0d_fail", i), 32'(fail));
    end

    // TX PLL stall: pulses at edges 16..19 and 36..39, FAIL at edge 56.
    do_reset();
    en = 1'b1; lane_mask = 4'hF; hsst_ch_ready = 4'hF;
    tick();
    for (int k = 1; k <= 60; k++) begin
      tick();
      exp_low = ((k >= 16 && k <= 19) || (k >= 36 && k <= 39));
      expect_val(32'(!exp_low)); check($sformatf("tx_k%0d_txpll_n", k), 32'(txpll_soft_rst_n));
      expect_val(32'(k >= 56));  check($sformatf("tx_k%0d_fail", k), 32'(fail));
      expect_val(4'hF);          check($sformatf("tx_k%0d_rxlane_n", k), 32'(rxlane_soft_rst_n));
    end
    expect_val(32'(S_FAIL)); check("tx_fail_state", 32'(sup_state));
    en = 1'b0;
    tick();
    expect_val(32'(S_IDLE)); check("tx_fail_exit_state", 32'(sup_state));
    expect_val(32'd0);       check("tx_fail_exit_fail", 32'(fail));

    // RX round-robin: lanes 0 and 2 stuck. Pulses start at 34+37*p,
    // alternating lane0/lane2, FAIL once lane0 comes round a third time.
    do_reset();
    en = 1'b1; lane_mask = 4'hF; hsst_ch_ready = 4'b1010;
    tick();
    tx_rst_done = 1'b1;
    for (int k = 1; k <= 190; k++) begin
      tick();
      exp_rxn = 4'hF;
      for (int q = 0; q < 4; q++) begin
        p = 34 + 37 * q;
        if (k >= p && k < p + 4) exp_rxn = (q % 2 == 0) ? 4'b1110 : 4'b1011;
      end
      expect_val(32'(exp_rxn));  check($sformatf("rx_k%0d_rxlane_n", k), 32'(rxlane_soft_rst_n));
      expect_val(32'(k >= 182)); check($sformatf("rx_k%0d_fail", k), 32'(fail));
      expect_val(32'd1);         check($sformatf("rx_k%0d_txpll_n", k), 32'(txpll_soft_rst_n));
      check_one_hot_reset();
      if (k == 33) begin
        expect_val(32'(S_SCAN)); check("rx_scan_state", 32'(sup_state));
      end
    end

    // en drop during the second cycle of an RX pulse.
    do_reset();
    en = 1'b1; lane_mask = 4'hF; hsst_ch_ready = 4'b1010;
    tick();
    tx_rst_done = 1'b1;
    for (int k = 1; k <= 35; k++) tick();
    expect_val(32'(S_RXR));   check("abort_pre_state", 32'(sup_state));
    expect_val(32'(4'b1110)); check("abort_pre_rxlane_n", 32'(rxlane_soft_rst_n));
    en = 1'b0;
    tick();
    expect_val(32'(S_IDLE));  check("abort_state", 32'(sup_state));
    expect_val(32'(4'hF));    check("abort_rxlane_n", 32'(rxlane_soft_rst_n));

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
